// File: rtl/voice_pkg.sv
// Shared types and default widths for the voice driver slice.
package voice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } env_state_t;

  localparam int RAMP_W           = 6;
  localparam int PHASE_W_DEF      = 24;
  localparam int SAMPLE_W_DEF     = 16;
  localparam int ENV_W_DEF        = 8;
  localparam int ATTACK_STEP_DEF  = 8;
  localparam int RELEASE_STEP_DEF = 2;

endpackage

// File: rtl/voice_driver_if.sv
// Note control, wavetable lookup and DAC handshake signals of one voice.
interface voice_driver_if
  import voice_pkg::*;
#(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
);

  logic                       i_note_on;
  logic                       i_note_off;
  logic [PHASE_W-1:0]         i_phase_inc;
  logic                       i_sample_tick;
  logic [RAMP_W-1:0]          o_ramp;
  logic signed [SAMPLE_W-1:0] i_music;
  logic signed [SAMPLE_W-1:0] o_sample;
  logic                       o_valid;
  logic                       i_ready;
  logic                       o_busy;
  logic                       o_overrun;

  // master is the voice itself; slave is the surrounding note logic, lookup and DAC path
  modport master (
    input  i_note_on, i_note_off, i_phase_inc, i_sample_tick, i_music, i_ready,
    output o_ramp, o_sample, o_valid, o_busy, o_overrun
  );

  modport slave (
    output i_note_on, i_note_off, i_phase_inc, i_sample_tick, i_music, i_ready,
    input  o_ramp, o_sample, o_valid, o_busy, o_overrun
  );

endinterface

// File: rtl/envelope_gen.sv
// Linear attack/release envelope FSM with a saturating magnitude counter.
module envelope_gen
  import voice_pkg::*;
#(
  parameter int ENV_W        = ENV_W_DEF,
  parameter int ATTACK_STEP  = ATTACK_STEP_DEF,
  parameter int RELEASE_STEP = RELEASE_STEP_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             note_on,
  input  logic             note_off,
  input  logic             tick,
  output logic [ENV_W-1:0] env,
  output logic             busy,
  output logic             phase_clr
);

  localparam logic [ENV_W-1:0] ENV_FULL = '1;

  env_state_t       state, state_next;
  logic [ENV_W-1:0] env_next;
  logic [ENV_W:0]   attack_sum;

  assign attack_sum = {1'b0, env} + (ENV_W + 1)'(ATTACK_STEP);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      env   <= '0;
    end else begin
      state <= state_next;
      env   <= env_next;
    end
  end

  // note_on takes priority over everything and keeps env, so a retrigger never clicks
  always_comb begin
    state_next = state;
    env_next   = env;
    if (note_on) begin
      state_next = ATTACK;
    end else begin
      case (state)
        ATTACK: begin
          if (note_off) begin
            state_next = RELEASE;
          end else if (tick) begin
            if (attack_sum > (ENV_W + 1)'(ENV_FULL)) env_next = ENV_FULL;
            else                                     env_next = attack_sum[ENV_W-1:0];
            if (env_next == ENV_FULL) state_next = SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (note_off) state_next = RELEASE;
        end
        RELEASE: begin
          if (tick) begin
            if (env <= ENV_W'(RELEASE_STEP)) env_next = '0;
            else                             env_next = env - ENV_W'(RELEASE_STEP);
            if (env_next == '0) state_next = IDLE;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    phase_clr = ((state == IDLE) && (state_next == ATTACK)) ||
                ((state == RELEASE) && (state_next == IDLE));
  end

endmodule

// File: rtl/voice_driver.sv
// One wavetable voice: phase ramp, enveloped sample capture and DAC-side handshake.
module voice_driver
  import voice_pkg::*;
#(
  parameter int PHASE_W      = PHASE_W_DEF,
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int ENV_W        = ENV_W_DEF,
  parameter int ATTACK_STEP  = ATTACK_STEP_DEF,
  parameter int RELEASE_STEP = RELEASE_STEP_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  voice_driver_if.master bus
);

  localparam int PROD_W = SAMPLE_W + ENV_W + 1;

  logic [PHASE_W-1:0]         phase;
  logic [PHASE_W-1:0]         phase_sum;
  logic [RAMP_W-1:0]          ramp;
  logic [ENV_W-1:0]           env;
  logic                       busy;
  logic                       phase_clr;
  logic                       load_pending;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       valid;
  logic                       overrun;
  logic signed [PROD_W-1:0]   music_ext;
  logic signed [PROD_W-1:0]   env_ext;

  envelope_gen #(
    .ENV_W        (ENV_W),
    .ATTACK_STEP  (ATTACK_STEP),
    .RELEASE_STEP (RELEASE_STEP)
  ) u_env (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .note_on   (bus.i_note_on),
    .note_off  (bus.i_note_off),
    .tick      (bus.i_sample_tick),
    .env       (env),
    .busy      (busy),
    .phase_clr (phase_clr)
  );

  assign phase_sum = phase + bus.i_phase_inc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phase <= '0;
      ramp  <= '0;
    end else if (phase_clr) begin
      phase <= '0;
      ramp  <= '0;
    end else if (bus.i_sample_tick && busy) begin
      phase <= phase_sum;
      ramp  <= phase_sum[PHASE_W-1 -: RAMP_W];
    end
  end

  // Full-width signed operands keep the product exact; env is zero-extended so it stays positive
  assign music_ext = PROD_W'(bus.i_music);
  assign env_ext   = PROD_W'(env);

  // A load one cycle after the tick sees the new ramp and env; an unconsumed sample blocks it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      load_pending <= 1'b0;
      sample       <= '0;
      valid        <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      load_pending <= bus.i_sample_tick;
      if (load_pending) begin
        if (valid && !bus.i_ready) begin
          overrun <= 1'b1;
        end else begin
          sample <= SAMPLE_W'((music_ext * env_ext) >>> ENV_W);
          valid  <= 1'b1;
        end
      end else if (valid && bus.i_ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.o_ramp    = ramp;
  assign bus.o_sample  = sample;
  assign bus.o_valid   = valid;
  assign bus.o_busy    = busy;
  assign bus.o_overrun = overrun;

endmodule

// File: tb/tb_voice_driver.sv
// Directed bench for voice_driver: envelope shape, ramp wrap, sign, retrigger, overrun and reset.
module tb_voice_driver;
  import voice_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   env_exp;
  int   ramp_exp;
  int   music;

  always #5 clk = ~clk;

  voice_driver_if bus ();

  voice_driver dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses the control inputs for exactly one rising edge
  task automatic applyStimulus(input logic on, input logic off, input logic tk);
    bus.i_note_on     = on;
    bus.i_note_off    = off;
    bus.i_sample_tick = tk;
    @(negedge clk);
    bus.i_note_on     = 1'b0;
    bus.i_note_off    = 1'b0;
    bus.i_sample_tick = 1'b0;
  endtask

  task automatic sampleTick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.i_note_on     = 1'b0;
    bus.i_note_off    = 1'b0;
    bus.i_sample_tick = 1'b0;
    bus.i_phase_inc   = 24'h040000;
    bus.i_music       = 16'h1000;
    bus.i_ready       = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ramp", 32'(bus.o_ramp), 0);
    checkOutput("rst_sample", 32'($unsigned(bus.o_sample)), 0);
    checkOutput("rst_valid", 32'(bus.o_valid), 0);
    checkOutput("rst_busy", 32'(bus.o_busy), 0);
    checkOutput("rst_overrun", 32'(bus.o_overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("on_busy", 32'(bus.o_busy), 1);
    checkOutput("on_state", 32'(dut.u_env.state), 32'(ATTACK));

    env_exp  = 0;
    ramp_exp = 0;
    for (int k = 1; k <= 64; k++) begin
      music       = (k == 16) ? -8192 : 4096;
      bus.i_music = 16'(music);
      env_exp     = (env_exp + 8 > 255) ? 255 : env_exp + 8;
      ramp_exp    = (ramp_exp + 1) % 64;
      sampleTick();
      checkOutput("attack_ramp", 32'(bus.o_ramp), 32'(ramp_exp));
      checkOutput("attack_sample", 32'($unsigned(bus.o_sample)), 32'(((music * env_exp) >>> 8) & 32'hFFFF));
      checkOutput("attack_valid", 32'(bus.o_valid), 1);
    end
    bus.i_music = 16'h1000;
    checkOutput("sustain_state", 32'(dut.u_env.state), 32'(SUSTAIN));
    @(negedge clk);
    checkOutput("consumed_valid", 32'(bus.o_valid), 0);

    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_state", 32'(dut.u_env.state), 32'(ATTACK));
    sampleTick();
    ramp_exp = (ramp_exp + 1) % 64;
    checkOutput("retrig_state", 32'(dut.u_env.state), 32'(SUSTAIN));
    checkOutput("retrig_sample", 32'($unsigned(bus.o_sample)), 32'h0FF0);
    checkOutput("retrig_ramp", 32'(bus.o_ramp), 32'(ramp_exp));

    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("off_state", 32'(dut.u_env.state), 32'(RELEASE));
    for (int k = 1; k <= 128; k++) begin
      env_exp  = (env_exp < 2) ? 0 : env_exp - 2;
      ramp_exp = (k == 128) ? 0 : (ramp_exp + 1) % 64;
      sampleTick();
      checkOutput("release_ramp", 32'(bus.o_ramp), 32'(ramp_exp));
      checkOutput("release_sample", 32'($unsigned(bus.o_sample)), 32'(env_exp * 16));
    end
    checkOutput("idle_busy", 32'(bus.o_busy), 0);
    checkOutput("idle_state", 32'(dut.u_env.state), 32'(IDLE));
    checkOutput("idle_phase", 32'(dut.phase), 0);

    sampleTick();
    checkOutput("idle_tick_sample", 32'($unsigned(bus.o_sample)), 0);
    checkOutput("idle_tick_valid", 32'(bus.o_valid), 1);
    checkOutput("idle_tick_ramp", 32'(bus.o_ramp), 0);
    @(negedge clk);
    checkOutput("idle_consumed", 32'(bus.o_valid), 0);

    bus.i_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    sampleTick();
    checkOutput("ovr_first_sample", 32'($unsigned(bus.o_sample)), 32'h0080);
    checkOutput("ovr_first_valid", 32'(bus.o_valid), 1);
    checkOutput("ovr_first_flag", 32'(bus.o_overrun), 0);
    checkOutput("ovr_first_ramp", 32'(bus.o_ramp), 1);
    sampleTick();
    checkOutput("ovr_held_sample", 32'($unsigned(bus.o_sample)), 32'h0080);
    checkOutput("ovr_held_valid", 32'(bus.o_valid), 1);
    checkOutput("ovr_flag", 32'(bus.o_overrun), 1);
    bus.i_ready = 1'b1;
    @(negedge clk);
    checkOutput("ovr_xfer_valid", 32'(bus.o_valid), 0);
    checkOutput("ovr_sticky", 32'(bus.o_overrun), 1);
    checkOutput("ovr_xfer_sample", 32'($unsigned(bus.o_sample)), 32'h0080);

    bus.i_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    sampleTick();
    checkOutput("pre_rst_valid", 32'(bus.o_valid), 1);
    checkOutput("pre_rst_sample", 32'($unsigned(bus.o_sample)), 32'h00E0);
    checkOutput("pre_rst_state", 32'(dut.u_env.state), 32'(RELEASE));
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_ramp", 32'(bus.o_ramp), 0);
    checkOutput("mid_rst_sample", 32'($unsigned(bus.o_sample)), 0);
    checkOutput("mid_rst_valid", 32'(bus.o_valid), 0);
    checkOutput("mid_rst_busy", 32'(bus.o_busy), 0);
    checkOutput("mid_rst_overrun", 32'(bus.o_overrun), 0);
    checkOutput("mid_rst_state", 32'(dut.u_env.state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_driver.md
Name: voice_driver

Overview:
- Drives the phase side of the wavetable timbre lookup: generates the 6-bit ramp index and captures the returned 16-bit signed sample.
- Applies a linear attack/release envelope to each captured sample.
- Presents one scaled sample per sample tick to the audio DAC path over a valid/ready handshake.
- Sits between the key/note logic (upstream) and the codec serializer (downstream).

Parameters:
PHASE_W, 24, phase accumulator width; ramp index = phase[PHASE_W-1 -: 6]
SAMPLE_W, 16, width of wavetable sample and output sample (signed two's complement)
ENV_W, 8, envelope magnitude width (0..255)
ATTACK_STEP, 8, envelope increment per sample tick in ATTACK
RELEASE_STEP, 2, envelope decrement per sample tick in RELEASE

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  synchronous active-low reset
i_note_on  input  1  single-cycle pulse: start or retrigger note
i_note_off  input  1  single-cycle pulse: release note
i_phase_inc  input  PHASE_W  phase increment per sample tick; sampled on the tick cycle
i_sample_tick  input  1  single-cycle pulse at the audio sample rate
o_ramp  output  6  wavetable index to the timbre lookup
i_music  input  SAMPLE_W  signed sample returned combinationally for o_ramp
o_sample  output  SAMPLE_W  enveloped signed sample
o_valid  output  1  o_sample holds an unconsumed sample
i_ready  input  1  downstream accepts o_sample when o_valid && i_ready
o_busy  output  1  envelope state != IDLE
o_overrun  output  1  sticky: a tick arrived while a sample was still pending

Behaviour:
- Reset is synchronous on i_rst_n=0. Reset values: phase=0, env=0, state=IDLE, o_ramp=0, o_sample=0, o_valid=0, o_busy=0, o_overrun=0. Reset mid-operation discards any pending sample.
- Envelope FSM states: IDLE, ATTACK, SUSTAIN, RELEASE. All transitions are evaluated every cycle; envelope steps occur only on i_sample_tick.
- IDLE + note_on -> ATTACK; phase cleared to 0.
- ATTACK/SUSTAIN/RELEASE + note_on -> ATTACK; phase and env are kept (retrigger, no click).
- ATTACK/SUSTAIN + note_off -> RELEASE.
- If note_on and note_off occur in the same cycle, note_on wins.
- ATTACK, on tick: env = min(env+ATTACK_STEP, 255). When env reaches 255 -> SUSTAIN.
- SUSTAIN: env holds at 255.
- RELEASE, on tick: env = max(env-RELEASE_STEP, 0). When env reaches 0 -> IDLE and phase is cleared to 0.
- note_off in IDLE or RELEASE is ignored.
- Pipeline, with the tick at cycle T:
  - T+1: phase <= phase + i_phase_inc (modulo 2^PHASE_W wrap); o_ramp <= new phase top 6 bits. In IDLE, phase is not advanced and o_ramp stays 0.
  - T+2: o_sample <= (i_music * {1'b0,env}) >>> ENV_W, using the env value updated at T+1. The signed 25-bit product is truncated to SAMPLE_W, which cannot overflow because env <= 255. o_valid <= 1.
  - Latency from tick to o_valid is 2 cycles.
  - In IDLE a tick still produces a sample, which is 0 (env=0), so the DAC stream stays continuous.
- Handshake:
  - o_sample and o_valid hold stable until o_valid && i_ready.
  - On that cycle o_valid drops, unless a new sample is loading in the same cycle; load wins and o_valid stays 1.
  - If the T+2 load occurs while o_valid=1 and i_ready=0, the new sample is dropped, the old one is held, and o_overrun is set. o_overrun is cleared only by reset.
- Ticks spaced closer than 2 cycles are illegal and the behaviour is unspecified.

Decomposition:
- Package voice_pkg holds:
  - env_state_t enum (IDLE, ATTACK, SUSTAIN, RELEASE)
  - RAMP_W=6
  - default widths and step constants
- Sub-module envelope_gen contains the FSM and saturating env counter. Its outputs are env and o_busy; its inputs are note_on, note_off and tick. voice_driver keeps the phase accumulator, multiply stage and handshake.

Test Plan:
1. Reset, then note_on and inc=0x040000 with ticks every 16 cycles: o_ramp steps 1,2,3… per tick and wraps 63->0 on the 64th tick. With a constant i_music=0x1000, o_sample follows env: 0x0080, 0x0100… up to 0x0FF0 at env=255, then state=SUSTAIN.
2. In SUSTAIN, note_off: env falls by 2 per tick and reaches 0 after 128 ticks. State goes to IDLE, o_busy=0, phase=0, and subsequent samples are 0x0000.
3. i_music=0xE000 (negative) at env=128: o_sample=0xF000, confirming the sign is preserved.
4. note_on and note_off in the same cycle from SUSTAIN: state=ATTACK and env is unchanged (255 -> immediately SUSTAIN on the next tick).
5. Hold i_ready=0 across two ticks: first sample held, second dropped, o_overrun=1. Raise i_ready: one transfer occurs, o_valid=0, o_overrun stays 1.
6. Assert i_rst_n=0 in RELEASE with o_valid=1: next cycle all outputs return to their reset values, and the state is IDLE.
